// File: rtl/wb_uart_tx_fifo.sv
// Wishbone byte FIFO that paces one-cycle strobes to a UART transmitter.
// A frame-time hold-off counter keeps strobes apart because the transmitter has no busy output.
module wb_uart_tx_fifo #(
   parameter int TICKS_PER_BAUD = 8,
   parameter int DEPTH_LOG2     = 4
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       wb_cyc_i,
   input  logic       wb_stb_i,
   input  logic       wb_we_i,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   output logic       wb_ack_o,
   output logic       tx_stb_o,
   output logic [7:0] tx_dat_o
);

   localparam int          DEPTH       = 1 << DEPTH_LOG2;
   localparam logic [11:0] FRAME_TICKS = 12'(10 * TICKS_PER_BAUD);

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level;
   logic [11:0]           holdoff;

   logic       full;
   logic       empty;
   logic       req;
   logic       push;
   logic       rd_acc;
   logic       pop;
   logic [7:0] status;

   assign full   = (level == (DEPTH_LOG2 + 1)'(DEPTH));
   assign empty  = (level == '0);
   // The !wb_ack_o term keeps a strobe held through its ack cycle from being taken twice.
   assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign push   = req & wb_we_i & ~full;
   assign rd_acc = req & ~wb_we_i;
   assign pop    = (holdoff == '0) & ~empty;
   assign status = {full, empty, 6'(level)};

   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wr_ptr] <= wb_dat_i;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         holdoff  <= '0;
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         tx_stb_o <= 1'b0;
         tx_dat_o <= '0;
      end else begin
         wb_ack_o <= push | rd_acc;
         if (rd_acc) wb_dat_o <= status;
         if (push) wr_ptr <= wr_ptr + 1'b1;

         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         tx_stb_o <= pop;
         if (pop) begin
            tx_dat_o <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
            holdoff  <= FRAME_TICKS;
         end else if (holdoff != '0) begin
            holdoff  <= holdoff - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_uart_tx_fifo.sv
// Scoreboarded bench for wb_uart_tx_fifo: bus tasks queue expected acks/strobes,
// a negedge monitor compares them and a small transmitter model watches for dropped strobes.
module tb_wb_uart_tx_fifo;

   localparam int TICKS = 8;
   localparam int DL2   = 2;
   localparam int FRAME = 10 * TICKS;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic       wb_cyc_i = 1'b0;
   logic       wb_stb_i = 1'b0;
   logic       wb_we_i  = 1'b0;
   logic [7:0] wb_dat_i = 8'h00;
   logic [7:0] wb_dat_o;
   logic       wb_ack_o;
   logic       tx_stb_o;
   logic [7:0] tx_dat_o;

   typedef struct {
      logic       is_rd;
      logic [7:0] dat;
      int         at;
   } exp_t;

   exp_t ack_q[$];
   exp_t stb_q[$];
   exp_t ea;
   exp_t es;

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int n;

   logic       tx_busy  = 1'b0;
   int         tx_age   = 0;
   logic [9:0] tx_frame = '1;
   logic       tx_line  = 1'b1;
   int         exp_line [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

   wb_uart_tx_fifo #(
      .TICKS_PER_BAUD (TICKS),
      .DEPTH_LOG2     (DL2)
   ) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_we_i  (wb_we_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .tx_stb_o (tx_stb_o),
      .tx_dat_o (tx_dat_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // cyc == k between rising edge k and k+1
   always @(posedge wb_clk_i) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d), cycle %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   task automatic push_stb(input logic [7:0] d, input int at);
      exp_t e;
      e.is_rd = 1'b0;
      e.dat   = d;
      e.at    = at;
      stb_q.push_back(e);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge wb_clk_i);
   endtask

   // Drives at the current falling edge; strobe stays high through the ack cycle.
   task automatic bus(input logic we, input logic [7:0] d, input int exp_at,
                      input logic [7:0] exp_stat);
      exp_t e;
      e.is_rd = ~we;
      e.dat   = exp_stat;
      e.at    = exp_at;
      ack_q.push_back(e);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_dat_i = d;
      for (int i = 0; i < 300; i++) begin
         @(negedge wb_clk_i);
         if (wb_ack_o) begin
            @(negedge wb_clk_i);
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            wb_we_i  = 1'b0;
            return;
         end
      end
      n_cmp++;
      n_bad++;
      $display("FAIL bus_ack_timeout: no ack within 300 cycles, required at cycle %0d", exp_at);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   always @(negedge wb_clk_i) begin
      if (tx_busy) begin
         tx_age = tx_age + 1;
         if (tx_age > FRAME) tx_busy = 1'b0;
      end
      if (!wb_rst_i) begin
         if (wb_ack_o) begin
            if (ack_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ack: ack at cycle %0d, none required", cyc);
            end else begin
               ea = ack_q.pop_front();
               chk("ack_cycle", cyc, ea.at);
               if (ea.is_rd) chk("status", int'(wb_dat_o), int'(ea.dat));
            end
         end
         if (tx_stb_o) begin
            chk("tx_not_busy", int'(tx_busy), 0);
            if (stb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_strobe: strobe 0x%0h at cycle %0d, none required",
                        tx_dat_o, cyc);
            end else begin
               es = stb_q.pop_front();
               chk("strobe_cycle", cyc, es.at);
               chk("strobe_data", int'(tx_dat_o), int'(es.dat));
            end
            tx_busy  = 1'b1;
            tx_age   = 0;
            tx_frame = {1'b1, tx_dat_o, 1'b0};
         end
      end
      tx_line = (tx_busy && tx_age >= 1) ? tx_frame[(tx_age - 1) / TICKS] : 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge wb_clk_i);
      chk("rst_ack", int'(wb_ack_o), 0);
      chk("rst_tx_stb", int'(tx_stb_o), 0);
      chk("rst_tx_dat", int'(tx_dat_o), 0);
      chk("rst_dat_o", int'(wb_dat_o), 0);
      wb_rst_i = 1'b0;

      bus(1'b0, 8'h00, cyc + 1, 8'h40);

      // single byte and its serialized line
      n = cyc;
      push_stb(8'hA5, n + 2);
      bus(1'b1, 8'hA5, cyc + 1, 8'h00);
      for (int b = 0; b < 10; b++) begin
         wait_until(n + 2 + 1 + TICKS * b + TICKS / 2);
         #1 chk("line_bit", int'(tx_line), exp_line[b]);
      end
      wait_until(n + 2 + FRAME + 3);

      // back-to-back bytes
      n = cyc;
      push_stb(8'h11, n + 2);
      push_stb(8'h22, n + 2 + (FRAME + 1));
      push_stb(8'h33, n + 2 + 2 * (FRAME + 1));
      bus(1'b1, 8'h11, cyc + 1, 8'h00);
      bus(1'b1, 8'h22, cyc + 1, 8'h00);
      bus(1'b1, 8'h33, cyc + 1, 8'h00);
      wait_until(n + 2 + 3 * (FRAME + 1) + 2);

      // fill to full, status 0x84, sixth write stalls until the next pop
      n = cyc;
      for (int i = 0; i < 6; i++) push_stb(8'hB0 + 8'(i), n + 2 + i * (FRAME + 1));
      for (int i = 0; i < 5; i++) bus(1'b1, 8'hB0 + 8'(i), cyc + 1, 8'h00);
      bus(1'b0, 8'h00, cyc + 1, 8'h84);
      bus(1'b1, 8'hB5, n + 2 + (FRAME + 1) + 1, 8'h00);
      bus(1'b0, 8'h00, cyc + 1, 8'h84);
      wait_until(n + 2 + 6 * (FRAME + 1) + 2);

      // strobe held through the ack cycle pushes once
      n = cyc;
      push_stb(8'h5A, n + 2);
      push_stb(8'h6B, n + 2 + (FRAME + 1));
      bus(1'b1, 8'h5A, cyc + 1, 8'h00);
      bus(1'b1, 8'h6B, cyc + 1, 8'h00);
      bus(1'b0, 8'h00, cyc + 1, 8'h01);
      wait_until(n + 2 + 2 * (FRAME + 1) + 2);

      // pointer wrap through a 4-deep buffer
      n = cyc;
      for (int i = 0; i < 10; i++) begin
         wait_until(n + i * (FRAME + 1));
         push_stb(8'(i), n + i * (FRAME + 1) + 2);
         bus(1'b1, 8'(i), cyc + 1, 8'h00);
      end
      wait_until(n + 9 * (FRAME + 1) + 4);
      bus(1'b0, 8'h00, cyc + 1, 8'h40);
      wait_until(n + 10 * (FRAME + 1) + 2);

      // asynchronous reset mid-frame with bytes queued
      n = cyc;
      push_stb(8'hC3, n + 2);
      bus(1'b1, 8'hC3, cyc + 1, 8'h00);
      bus(1'b1, 8'hD4, cyc + 1, 8'h00);
      bus(1'b1, 8'hE5, cyc + 1, 8'h00);
      wait_until(n + 30);
      @(posedge wb_clk_i);
      #2 wb_rst_i = 1'b1;
      #1;
      chk("midrst_tx_dat", int'(tx_dat_o), 0);
      chk("midrst_dat_o", int'(wb_dat_o), 0);
      chk("midrst_ack", int'(wb_ack_o), 0);
      chk("midrst_tx_stb", int'(tx_stb_o), 0);
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      bus(1'b0, 8'h00, cyc + 1, 8'h40);
      repeat (200) @(negedge wb_clk_i);

      chk("pending_acks", ack_q.size(), 0);
      chk("pending_strobes", stb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_uart_tx_fifo.md
# wb_uart_tx_fifo

Wishbone slave that buffers bytes written by the CPU and feeds them one at a time to the downstream UART transmitter's strobe/data inputs. The transmitter has no busy or ready output, so this block paces its strobes with an internal frame-time hold-off counter. With the pacing, no byte is strobed while the transmitter is still shifting out the previous frame. It sits between the system Wishbone bus and the UART transmit serializer.

## Interface
- `TICKS_PER_BAUD`, default 8: clock cycles per UART bit. Range 1..255; must equal the transmitter's value.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes. Range 1..5.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, asynchronous and active-high.
- `wb_cyc_i` in 1: bus cycle valid.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: 1 = write (push byte), 0 = read (status).
- `wb_dat_i` in 8: byte to push.
- `wb_dat_o` out 8: status on read: bit7 full, bit6 empty, bits5:0 fill level.
- `wb_ack_o` out 1: one-cycle registered acknowledge.
- `tx_stb_o` out 1: one-cycle strobe to the transmitter.
- `tx_dat_o` out 8: byte presented with `tx_stb_o`.

## Operation
- **Storage:** circular buffer of 2^DEPTH_LOG2 bytes.
  - Read/write pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - Level counter is DEPTH_LOG2+1 bits, range 0..DEPTH.
  - full = (level == DEPTH); empty = (level == 0).
- **Bus request:** a request is present when `wb_cyc_i & wb_stb_i & !wb_ack_o`. The `!wb_ack_o` term prevents double acceptance of a strobe still held during its ack cycle.
- **Read request:**
  - Always accepted.
  - `wb_ack_o` goes high the next cycle.
  - `wb_dat_o` carries the status sampled at the accepting edge.
- **Write request, not full:**
  - Byte is written at the write pointer; the pointer and level increment.
  - `wb_ack_o` goes high the next cycle.
- **Write request, full:** not accepted and no ack (wait states). The master keeps the strobe asserted until a pop frees space; it is accepted on the first edge where level < DEPTH.
- **Hold-off counter:** 12 bits, reset 0, decrements when nonzero.
- **Pop:** occurs when the counter is 0 and the FIFO is not empty. On the pop edge:
  - `tx_stb_o` <= 1 and `tx_dat_o` <= head byte.
  - Read pointer increments and level decrements.
  - Counter is loaded with 10*TICKS_PER_BAUD.
- **When no pop occurs:** `tx_stb_o` <= 0 and `tx_dat_o` holds its last value.
- **Push and pop on the same edge:** both take effect and the level is unchanged. A push while full is never combined with a pop in that edge; it is accepted on the following edge.
- **Writes while idle and empty:** when the counter is 0 and the FIFO is empty, a write makes the byte eligible to pop on the next edge.
- **Reset (asynchronous, at any time, including mid-frame or mid-wait-state):**
  - Pointers, level, and counter go to 0.
  - `wb_ack_o`, `tx_stb_o`, `tx_dat_o`, and `wb_dat_o` go to 0.
  - Buffered bytes are discarded.

## Timing
- Every output is registered and all state updates on the rising edge of `wb_clk_i`.
- **Ack latency:** ack is asserted in the cycle after the accepting edge, for exactly one cycle.
- **Write to strobe:** write accepted at edge k into an empty FIFO with counter 0 → `tx_stb_o` high in the cycle after edge k+1.
- **Strobe spacing:** consecutive strobes are exactly 10*TICKS_PER_BAUD+1 cycles apart while data is available. This equals one transmitter frame (start, 8 data bits, stop) plus the cycle the transmitter needs to re-enter idle.
- **Throughput:** the bus can fill 2^DEPTH_LOG2 bytes back-to-back at one write per 2 cycles.

## Test plan
- **Reset state:** assert `wb_rst_i` mid-frame with 3 bytes queued, asynchronously between edges. Required: outputs go to 0 immediately; after release, a status read returns 0x40 (empty, level 0); no `tx_stb_o` occurs.
- **Single byte:** TICKS_PER_BAUD=8, write 0xA5. Required: ack 1 cycle later; `tx_stb_o` one cycle with `tx_dat_o`=0xA5 at 2 cycles after the accepting edge. Checked against the transmitter model, line output 0,1,0,1,0,0,1,0,1,1 per 8-cycle bit.
- **Back-to-back bytes:** write 0x11, 0x22, 0x33 consecutively. Required: strobes exactly 81 cycles apart in order 0x11, 0x22, 0x33; the transmitter model never drops a strobe.
- **Full FIFO:** DEPTH_LOG2=2, write 5 bytes while the first is in flight. Required: status reads 0x84 (full, level 4) after write 5 is accepted; write 6 stalls without ack until the next pop, then is acked exactly one cycle after that pop edge.
- **Ack rule with held strobe:** master holds `wb_stb_i` high across the ack cycle. Required: exactly one byte pushed and exactly one ack pulse.
- **Pointer wrap:** DEPTH_LOG2=2, push and pop 10 bytes 0x00..0x09. Required: output order preserved across wrap; final status 0x40.
